// File: rtl/regbank_pkg.sv
// Shared types and sizes for the 16-entry register-file write side.
package regbank_pkg;

  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;

  typedef logic [ADDR_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/decoder4_16.sv
// 4-to-16 one-hot decoder; all outputs low when en is low.
module decoder4_16
  import regbank_pkg::*;
(
  input  logic                en,
  input  reg_idx_t            sel,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/reg_write_bank.sv
// Write side of the 16-entry register file: handshaked writes plus a one-entry-per-cycle clear sweep.
// Build option: REG_WRITE_BANK_ZERO_REG_EN makes entry 15 a hardwired zero.
module reg_write_bank
  import regbank_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      clr_req,
  output logic                      clr_busy,
  output logic                      clr_done,
  output logic [NUM_REGS-1:0]       wr_onehot,
  output logic [NUM_REGS*WIDTH-1:0] regs_out,
  output state_t                    state_dbg
);

  // Handshake: a write transfers on a rising edge where wr_valid && wr_ready;
  // wr_ready never depends on wr_valid, and the source holds addr/data until then.

  state_t              state_q, state_d;
  reg_idx_t            ptr_q;
  logic                run_q;
  logic                wr_accept;
  logic                dec_en;
  reg_idx_t            dec_sel;
  logic [NUM_REGS-1:0] dec_onehot;
  logic [NUM_REGS-1:0] wr_en_vec;
  logic                clearing;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (state_q == IDLE) begin
        ptr_q <= '0;
      end else if (state_q == CLEAR && ptr_q != reg_idx_t'(NUM_REGS - 1)) begin
        ptr_q <= ptr_q + 1'b1;
      end
    end
  end

  // One decoder serves both the write port and the sweep pointer.
  always_comb begin
    state_d   = state_q;
    wr_ready  = 1'b0;
    wr_accept = 1'b0;
    dec_en    = 1'b0;
    dec_sel   = wr_addr;
    case (state_q)
      IDLE: begin
        wr_ready  = run_q && !clr_req;
        wr_accept = wr_valid && wr_ready;
        dec_en    = wr_accept;
        if (clr_req) state_d = CLEAR;
      end
      CLEAR: begin
        dec_en  = 1'b1;
        dec_sel = ptr_q;
        if (ptr_q == reg_idx_t'(NUM_REGS - 1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  decoder4_16 u_dec (
    .en     (dec_en),
    .sel    (dec_sel),
    .onehot (dec_onehot)
  );

`ifdef REG_WRITE_BANK_ZERO_REG_EN
  assign wr_en_vec = dec_onehot & {1'b0, {(NUM_REGS-1){1'b1}}};
`else
  assign wr_en_vec = dec_onehot;
`endif

  assign clearing  = (state_q == CLEAR);
  assign wr_onehot = wr_en_vec;
  assign clr_busy  = (state_q != IDLE);
  assign clr_done  = (state_q == DONE);
  assign state_dbg = state_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
    logic [WIDTH-1:0] entry_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        entry_q <= '0;
      end else if (wr_en_vec[i]) begin
        entry_q <= clearing ? '0 : wr_data;
      end
    end

`ifdef REG_WRITE_BANK_ZERO_REG_EN
    assign regs_out[i*WIDTH +: WIDTH] = (i == NUM_REGS - 1) ? '0 : entry_q;
`else
    assign regs_out[i*WIDTH +: WIDTH] = entry_q;
`endif
  end

endmodule
